// File: rtl/cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// cpu_run_monitor
//
// Run controller and monitor for a CPU core. It sequences the core's reset,
// counts executed cycles, stops the run on a halt instruction, a PC stall
// or a timeout, and keeps a ring-buffer trace of the most recent PCs.
//
// Ports:
//   clk        in   1              system clock, rising edge
//   rst        in   1              asynchronous active-low reset of this block
//   start      in   1              run request pulse, honoured in IDLE or DONE
//   pc         in   ADDR_LEN       CPU program counter
//   inst       in   INSTR_LEN      CPU current instruction
//   cpu_rst    out  1              active-high reset to the CPU
//   running    out  1              high while in RUN
//   done       out  1              high while in DONE
//   status     out  2              00 none, 01 halt, 10 stall, 11 timeout
//   cycles     out  CNT_W          RUN cycles completed in current/last run
//   trace_idx  in   log2(DEPTH)    trace read index, 0 = most recent
//   trace_pc   out  ADDR_LEN       trace entry at trace_idx (combinational)
//   trace_cnt  out  log2(DEPTH)+1  valid trace entries, saturating at DEPTH
// ---------------------------------------------------------------------------
module cpu_run_monitor #(
  parameter int                   ADDR_LEN     = 32,
  parameter int                   INSTR_LEN    = 32,
  parameter int                   RESET_CYCLES = 1,
  parameter int                   MAX_CYCLES   = 100,
  parameter int                   STALL_LIMIT  = 8,
  parameter logic [INSTR_LEN-1:0] HALT_INST    = 32'hFFFF_FFFF,
  parameter int                   TRACE_DEPTH  = 8,
  parameter int                   CNT_W        = 16,
  // derived widths, not meant to be overridden
  parameter int                   IDX_W        = $clog2(TRACE_DEPTH),
  parameter int                   TCNT_W       = IDX_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_LEN-1:0]  pc,
  input  logic [INSTR_LEN-1:0] inst,
  output logic                 cpu_rst,
  output logic                 running,
  output logic                 done,
  output logic [1:0]           status,
  output logic [CNT_W-1:0]     cycles,
  input  logic [IDX_W-1:0]     trace_idx,
  output logic [ADDR_LEN-1:0]  trace_pc,
  output logic [TCNT_W-1:0]    trace_cnt
);

  localparam int RST_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_HALT    = 2'b01;
  localparam logic [1:0] ST_STALL   = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t               r_state;
  logic [RST_W-1:0]     r_rst_cnt;
  logic [CNT_W-1:0]     r_cycles;
  logic [1:0]           r_status;
  logic [STALL_W-1:0]   r_stall_cnt;
  logic [ADDR_LEN-1:0]  r_prev_pc;
  logic [IDX_W-1:0]     r_wr_ptr;
  logic [TCNT_W-1:0]    r_trace_cnt;
  logic                 r_cpu_rst;
  logic                 r_running;
  logic                 r_done;
  logic [ADDR_LEN-1:0]  r_trace [TRACE_DEPTH];

  // -------------------------------------------------------------------------
  // Next-state / control signals
  // -------------------------------------------------------------------------
  state_t               w_state_next;
  logic [RST_W-1:0]     w_rst_cnt_next;
  logic [1:0]           w_status_next;
  logic                 w_clear;      // start of a new run: wipe run results
  logic                 w_run_step;   // one executed RUN cycle at this edge
  logic [CNT_W-1:0]     w_cycles_inc;
  logic [STALL_W-1:0]   w_stall_inc;
  logic                 w_trace_full;
  logic [IDX_W-1:0]     w_rd_ptr;
  logic                 w_rd_valid;

  assign w_cycles_inc = r_cycles + CNT_W'(1);

  // The first RUN cycle of a run has no previous pc to compare against;
  // r_cycles is still zero then because every run starts with a clear.
  assign w_stall_inc = ((r_cycles == '0) || (pc != r_prev_pc))
                       ? STALL_W'(1)
                       : r_stall_cnt + STALL_W'(1);

  assign w_trace_full = (r_trace_cnt == TCNT_W'(TRACE_DEPTH));

  // -------------------------------------------------------------------------
  // FSM: next state, status and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_rst_cnt_next = r_rst_cnt;
    w_status_next  = r_status;
    w_clear        = 1'b0;
    w_run_step     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_clear = 1'b1;
        if (start) begin
          w_state_next   = S_RESET;
          w_rst_cnt_next = '0;
        end
      end

      S_RESET: begin
        if (r_rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
          w_state_next = S_RUN;
        end else begin
          w_rst_cnt_next = r_rst_cnt + RST_W'(1);
        end
      end

      S_RUN: begin
        w_run_step = 1'b1;
        // Termination is judged on the values this edge records, so the
        // final cycle and trace entry land together with the move to DONE.
        if (inst == HALT_INST) begin
          w_status_next = ST_HALT;
          w_state_next  = S_DONE;
        end else if (w_stall_inc == STALL_W'(STALL_LIMIT)) begin
          w_status_next = ST_STALL;
          w_state_next  = S_DONE;
        end else if (w_cycles_inc == CNT_W'(MAX_CYCLES)) begin
          w_status_next = ST_TIMEOUT;
          w_state_next  = S_DONE;
        end
      end

      S_DONE: begin
        if (start) begin
          w_clear        = 1'b1;
          w_state_next   = S_RESET;
          w_rst_cnt_next = '0;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (w_clear) begin
      w_status_next = ST_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rst_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rst_cnt <= w_rst_cnt_next;
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cpu_rst <= 1'b1;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_status  <= ST_NONE;
    end else begin
      r_cpu_rst <= (w_state_next != S_RUN);
      r_running <= (w_state_next == S_RUN);
      r_done    <= (w_state_next == S_DONE);
      r_status  <= w_status_next;
    end
  end

  // -------------------------------------------------------------------------
  // Run datapath: cycle count, stall tracking, trace pointer and count
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycles    <= '0;
      r_stall_cnt <= '0;
      r_prev_pc   <= '0;
      r_wr_ptr    <= '0;
      r_trace_cnt <= '0;
    end else if (w_clear) begin
      r_cycles    <= '0;
      r_stall_cnt <= '0;
      r_wr_ptr    <= '0;
      r_trace_cnt <= '0;
    end else if (w_run_step) begin
      r_cycles    <= w_cycles_inc;
      r_stall_cnt <= w_stall_inc;
      r_prev_pc   <= pc;
      r_wr_ptr    <= r_wr_ptr + IDX_W'(1);   // wraps: depth is a power of two
      if (!w_trace_full) begin
        r_trace_cnt <= r_trace_cnt + TCNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Trace storage: one register per entry so the whole buffer clears on
  // reset and can be read combinationally.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < TRACE_DEPTH; gi++) begin : g_trace
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_trace[gi] <= '0;
        end else if (w_run_step && (r_wr_ptr == IDX_W'(gi))) begin
          r_trace[gi] <= pc;
        end
      end
    end
  endgenerate

  // r_wr_ptr points at the next slot, so the newest entry sits one behind it.
  assign w_rd_ptr   = r_wr_ptr - trace_idx - IDX_W'(1);
  assign w_rd_valid = ({1'b0, trace_idx} < r_trace_cnt);

  assign trace_pc  = w_rd_valid ? r_trace[w_rd_ptr] : '0;
  assign trace_cnt = r_trace_cnt;
  assign cpu_rst   = r_cpu_rst;
  assign running   = r_running;
  assign done      = r_done;
  assign status    = r_status;
  assign cycles    = r_cycles;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_monitor
//
// Directed bench for cpu_run_monitor with default parameters. The bench
// plays the CPU by driving pc/inst for every RUN cycle; all expected values
// are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_cpu_run_monitor;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        cpu_rst;
  logic        running;
  logic        done;
  logic [1:0]  status;
  logic [15:0] cycles;
  logic [2:0]  trace_idx;
  logic [31:0] trace_pc;
  logic [3:0]  trace_cnt;

  int n_compared   = 0;
  int n_mismatched = 0;

  cpu_run_monitor #(
    .ADDR_LEN     (32),
    .INSTR_LEN    (32),
    .RESET_CYCLES (1),
    .MAX_CYCLES   (100),
    .STALL_LIMIT  (8),
    .HALT_INST    (32'hFFFF_FFFF),
    .TRACE_DEPTH  (8),
    .CNT_W        (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pc        (pc),
    .inst      (inst),
    .cpu_rst   (cpu_rst),
    .running   (running),
    .done      (done),
    .status    (status),
    .cycles    (cycles),
    .trace_idx (trace_idx),
    .trace_pc  (trace_pc),
    .trace_cnt (trace_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // advance one clock; inputs and samples sit 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start pulse, one RESET cycle, then the DUT is in RUN with no cycle done
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    pc        = '0;
    inst      = '0;
    trace_idx = '0;
    #2 rst = 1'b0;
    tick();
    tick();

    // ---------------- reset state
    check_val("rst_cpu_rst",   cpu_rst,   1);
    check_val("rst_running",   running,   0);
    check_val("rst_done",      done,      0);
    check_val("rst_status",    status,    0);
    check_val("rst_cycles",    cycles,    0);
    check_val("rst_trace_cnt", trace_cnt, 0);
    check_val("rst_trace_pc",  trace_pc,  0);
    rst = 1'b1;
    tick();
    check_val("idle_cpu_rst", cpu_rst, 1);

    // ---------------- basic run to timeout
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("seq_reset_cpu_rst", cpu_rst, 1);
    check_val("seq_reset_running", running, 0);
    tick();
    check_val("seq_run_cpu_rst", cpu_rst, 0);
    check_val("seq_run_running", running, 1);
    check_val("seq_run_cycles0", cycles,  0);
    for (int n = 0; n < 100; n++) begin
      pc = 32'(4 * n);
      inst = NOP;
      tick();
      if (n == 0)  check_val("to_cycles1",   cycles, 1);
      if (n == 98) check_val("to_done_at99", done,   0);
    end
    check_val("to_done",    done,    1);
    check_val("to_status",  status,  2'b11);
    check_val("to_cycles",  cycles,  100);
    check_val("to_cpu_rst", cpu_rst, 1);
    check_val("to_running", running, 0);

    // ---------------- halt on 5th RUN cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("halt_clr_cycles", cycles,    0);
    check_val("halt_clr_status", status,    0);
    check_val("halt_clr_tcnt",   trace_cnt, 0);
    tick();
    for (int k = 1; k <= 5; k++) begin
      pc = 32'(4 * (k - 1));
      inst = (k == 5) ? HALT : NOP;
      tick();
      if (k == 4) check_val("halt_running_at4", running, 1);
    end
    inst = NOP;
    check_val("halt_status",  status,  2'b01);
    check_val("halt_cycles",  cycles,  5);
    check_val("halt_done",    done,    1);
    check_val("halt_cpu_rst", cpu_rst, 1);
    pc = 32'h1234;
    tick();
    tick();
    check_val("halt_hold_cycles", cycles,    5);
    check_val("halt_hold_tcnt",   trace_cnt, 5);
    check_val("halt_hold_status", status,    2'b01);
    trace_idx = 3'd0;
    #1 check_val("halt_idx0", trace_pc, 32'h10);
    trace_idx = 3'd3;
    #1 check_val("halt_idx3", trace_pc, 32'h4);
    trace_idx = 3'd5;
    #1 check_val("halt_idx5_invalid", trace_pc, 0);
    trace_idx = 3'd0;

    // ---------------- stall: pc stuck at 0x40 from RUN cycle 10
    do_start();
    for (int k = 1; k <= 17; k++) begin
      pc = (k >= 10) ? 32'h40 : 32'(4 * (k - 1));
      tick();
      if (k == 16) check_val("stall_done_at16", done, 0);
    end
    check_val("stall_status", status, 2'b10);
    check_val("stall_cycles", cycles, 17);
    check_val("stall_done",   done,   1);

    // ---------------- trace wrap: 20 RUN cycles, pc = 4*n
    do_start();
    for (int n = 0; n < 20; n++) begin
      pc = 32'(4 * n);
      inst = (n == 19) ? HALT : NOP;
      tick();
    end
    inst = NOP;
    check_val("wrap_cycles", cycles,    20);
    check_val("wrap_tcnt",   trace_cnt, 8);
    trace_idx = 3'd0;
    #1 check_val("wrap_idx0", trace_pc, 32'h4C);
    trace_idx = 3'd3;
    #1 check_val("wrap_idx3", trace_pc, 32'h40);
    trace_idx = 3'd7;
    #1 check_val("wrap_idx7", trace_pc, 32'h30);

    // restart: in RESET, before any RUN cycle
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("restart_tcnt", trace_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      trace_idx = 3'(i);
      #1 check_val($sformatf("restart_idx%0d", i), trace_pc, 0);
    end
    trace_idx = 3'd0;
    tick();

    // ---------------- halt, stall limit and MAX_CYCLES on the same cycle
    for (int k = 1; k <= 100; k++) begin
      pc = (k >= 93) ? 32'h200 : 32'(4 * (k - 1));
      inst = (k == 100) ? HALT : NOP;
      tick();
      if (k == 99) check_val("simul_done_at99", done, 0);
    end
    inst = NOP;
    check_val("simul_status", status, 2'b01);
    check_val("simul_cycles", cycles, 100);

    // stall limit and MAX_CYCLES together without halt
    do_start();
    for (int k = 1; k <= 100; k++) begin
      pc = (k >= 93) ? 32'h200 : 32'(4 * (k - 1));
      tick();
    end
    check_val("stall_vs_to_status", status, 2'b10);
    check_val("stall_vs_to_cycles", cycles, 100);

    // ---------------- start during RUN, then async reset mid-RUN
    do_start();
    for (int k = 1; k <= 10; k++) begin
      pc = 32'(4 * (k - 1));
      start = (k == 5);
      tick();
    end
    start = 1'b0;
    check_val("midrun_cycles",  cycles,  10);
    check_val("midrun_running", running, 1);
    #2 rst = 1'b0;
    #1;
    check_val("async_cpu_rst", cpu_rst,   1);
    check_val("async_running", running,   0);
    check_val("async_done",    done,      0);
    check_val("async_cycles",  cycles,    0);
    check_val("async_status",  status,    0);
    check_val("async_tcnt",    trace_cnt, 0);
    #1 rst = 1'b1;
    tick();
    check_val("post_rst_running", running, 0);
    check_val("post_rst_cpu_rst", cpu_rst, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

endmodule
